// File: rtl/midi_pkg.sv
// ============================================================================
// Module  : midi_pkg
// Brief   : MIDI status-nibble constants and note-decoder parser states.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package midi_pkg;

    localparam logic [3:0] NOTE_OFF         = 4'h8;
    localparam logic [3:0] NOTE_ON          = 4'h9;
    localparam logic [3:0] CTRL             = 4'hB;
    localparam logic [3:0] PROG             = 4'hC;
    localparam logic [3:0] CHPRESS          = 4'hD;
    localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_D1 = 2'd1,
        ST_WAIT_D2 = 2'd2,
        ST_SKIP    = 2'd3
    } parser_state_t;

    // Program change and channel pressure carry a single data byte.
    function automatic logic is_one_data_byte(input logic [3:0] nibble);
        return (nibble == PROG) || (nibble == CHPRESS);
    endfunction

endpackage

`default_nettype wire

// File: rtl/midi_note_decoder.sv
// ============================================================================
// Module  : midi_note_decoder
// Brief   : Parses a MIDI byte stream into monophonic note-on/release events.
//           Optional: MIDI_RUNNING_STATUS_EN keeps the status after a message.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module midi_note_decoder
    import midi_pkg::*;
#(
    parameter logic [3:0] CHANNEL = 4'd0,
    parameter logic       OMNI    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       new_note_pulse,
    output logic       release_note_pulse,
    output logic [6:0] note,
    output logic [6:0] velocity,
    output logic       gate
);

    parser_state_t r_state, w_state_nx;
    logic [7:0]    r_status, w_status_nx;
    logic [6:0]    r_d1, w_d1_nx;
    logic          r_new, w_new_nx;
    logic          r_rel, w_rel_nx;
    logic [6:0]    r_note, w_note_nx;
    logic [6:0]    r_vel, w_vel_nx;
    logic          r_gate, w_gate_nx;
    logic          w_done;
    logic [6:0]    w_d2;
    logic          w_ch_match;

    assign w_ch_match = OMNI || (r_status[3:0] == CHANNEL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_status <= 8'h00;
            r_d1     <= 7'd0;
            r_new    <= 1'b0;
            r_rel    <= 1'b0;
            r_note   <= 7'd0;
            r_vel    <= 7'd0;
            r_gate   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_status <= w_status_nx;
            r_d1     <= w_d1_nx;
            r_new    <= w_new_nx;
            r_rel    <= w_rel_nx;
            r_note   <= w_note_nx;
            r_vel    <= w_vel_nx;
            r_gate   <= w_gate_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_status_nx = r_status;
        w_d1_nx     = r_d1;
        w_new_nx    = 1'b0;
        w_rel_nx    = 1'b0;
        w_note_nx   = r_note;
        w_vel_nx    = r_vel;
        w_gate_nx   = r_gate;
        w_done      = 1'b0;
        w_d2        = 7'd0;

        // Real-time bytes (0xF8-0xFF) fall through untouched.
        if (rx_valid && (rx_data < 8'hF8)) begin
            if (rx_data >= 8'hF0) begin
                w_status_nx = 8'h00;
                w_state_nx  = ST_SKIP;
            end else if (rx_data[7]) begin
                w_status_nx = rx_data;
                w_state_nx  = ST_WAIT_D1;
            end else begin
                unique case (r_state)
                    ST_WAIT_D1: begin
                        if (is_one_data_byte(r_status[7:4])) begin
                            w_done = 1'b1;
                        end else begin
                            w_d1_nx    = rx_data[6:0];
                            w_state_nx = ST_WAIT_D2;
                        end
                    end
                    ST_WAIT_D2: begin
                        w_done = 1'b1;
                        w_d2   = rx_data[6:0];
                    end
                    default: ;
                endcase
            end
        end

        if (w_done) begin
`ifdef MIDI_RUNNING_STATUS_EN
            w_state_nx  = ST_WAIT_D1;
`else
            w_state_nx  = ST_IDLE;
            w_status_nx = 8'h00;
`endif
            if (w_ch_match) begin
                if ((r_status[7:4] == NOTE_ON) && (w_d2 != 7'd0)) begin
                    w_new_nx  = 1'b1;
                    w_note_nx = r_d1;
                    w_vel_nx  = w_d2;
                    w_gate_nx = 1'b1;
                end else if ((r_status[7:4] == NOTE_OFF) || (r_status[7:4] == NOTE_ON)) begin
                    if (r_gate && (r_d1 == r_note)) begin
                        w_rel_nx  = 1'b1;
                        w_gate_nx = 1'b0;
                    end
                end else if ((r_status[7:4] == CTRL) && (r_d1 == CC_ALL_NOTES_OFF) && r_gate) begin
                    w_rel_nx  = 1'b1;
                    w_gate_nx = 1'b0;
                end
            end
        end
    end

    assign new_note_pulse     = r_new;
    assign release_note_pulse = r_rel;
    assign note               = r_note;
    assign velocity           = r_vel;
    assign gate               = r_gate;

endmodule

`default_nettype wire

// File: tb/tb_midi_note_decoder.sv
// ============================================================================
// Module  : tb_midi_note_decoder
// Brief   : Scoreboard bench: message-level reference model vs. decoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_midi_note_decoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       new_note_pulse;
    logic       release_note_pulse;
    logic [6:0] note;
    logic [6:0] velocity;
    logic       gate;

    typedef struct packed {
        logic       nw;
        logic       rl;
        logic [6:0] nt;
        logic [6:0] vl;
        logic       gt;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    logic seen   = 1'b0;

    // Reference model: status byte plus collected data bytes of the message.
    int         m_status;
    int         m_data[$];
    logic [6:0] m_note;
    logic [6:0] m_vel;
    logic       m_gate;

    midi_note_decoder #(.CHANNEL(4'd0), .OMNI(1'b0)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .rx_data            (rx_data),
        .rx_valid           (rx_valid),
        .new_note_pulse     (new_note_pulse),
        .release_note_pulse (release_note_pulse),
        .note               (note),
        .velocity           (velocity),
        .gate               (gate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) seen <= rx_valid;

    function automatic exp_t dut_out();
        exp_t a;
        a.nw = new_note_pulse;
        a.rl = release_note_pulse;
        a.nt = note;
        a.vl = velocity;
        a.gt = gate;
        return a;
    endfunction

    always @(negedge clk) begin
        exp_t e, a;
        a = dut_out();
        if (seen) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: output for byte with no expectation, got %h", a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL byte_response: got new=%b rel=%b note=%h vel=%h gate=%b, expected new=%b rel=%b note=%h vel=%h gate=%b",
                             a.nw, a.rl, a.nt, a.vl, a.gt, e.nw, e.rl, e.nt, e.vl, e.gt);
                end
            end
        end else begin
            checks++;
            if (new_note_pulse || release_note_pulse) begin
                errors++;
                $display("FAIL idle_pulse: got new=%b rel=%b, expected both 0", new_note_pulse, release_note_pulse);
            end
        end
    end

    task automatic model_reset();
        m_status = -1;
        m_data.delete();
        m_note = 7'd0;
        m_vel  = 7'd0;
        m_gate = 1'b0;
    endtask

    function automatic int msg_len(input int s);
        return (((s >> 4) == 12) || ((s >> 4) == 13)) ? 1 : 2;
    endfunction

    task automatic model_byte(input logic [7:0] b, output exp_t e);
        int kind;
        e = '0;
        if (b >= 8'hF8) begin
        end else if (b >= 8'hF0) begin
            m_status = -1;
            m_data.delete();
        end else if (b[7]) begin
            m_status = int'(b);
            m_data.delete();
        end else if (m_status >= 0) begin
            m_data.push_back(int'(b));
            if (m_data.size() == msg_len(m_status)) begin
                kind = m_status >> 4;
                if ((m_status & 15) == 0) begin
                    if (kind == 9 && m_data[1] != 0) begin
                        e.nw   = 1'b1;
                        m_note = 7'(m_data[0]);
                        m_vel  = 7'(m_data[1]);
                        m_gate = 1'b1;
                    end else if (kind == 8 || kind == 9) begin
                        if (m_gate && m_data[0] == int'(m_note)) begin
                            e.rl   = 1'b1;
                            m_gate = 1'b0;
                        end
                    end else if (kind == 11 && m_data[0] == 123 && m_gate) begin
                        e.rl   = 1'b1;
                        m_gate = 1'b0;
                    end
                end
                m_data.delete();
`ifndef MIDI_RUNNING_STATUS_EN
                m_status = -1;
`endif
            end
        end
        e.nt = m_note;
        e.vl = m_vel;
        e.gt = m_gate;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        exp_t e;
        model_byte(b, e);
        exp_q.push_back(e);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_seq(input logic [7:0] s[], input int gap);
        foreach (s[i]) send_byte(s[i], gap);
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [7:0] rand_byte();
        int r, p;
        logic [3:0] nib [8] = '{4'h8, 4'h9, 4'h9, 4'hB, 4'hC, 4'hD, 4'hA, 4'hE};
        logic [6:0] dat [6] = '{7'h3C, 7'h3D, 7'h3E, 7'd0, 7'd123, 7'h64};
        r = $urandom_range(0, 99);
        if (r < 30) begin
            p = $urandom_range(0, 7);
            return {nib[p], ($urandom_range(0, 9) < 7) ? 4'h0 : 4'($urandom_range(0, 15))};
        end else if (r < 80) begin
            if ($urandom_range(0, 1) == 0) return {1'b0, dat[$urandom_range(0, 5)]};
            return 8'($urandom_range(0, 127));
        end else if (r < 88) begin
            return 8'($urandom_range(8'hF8, 8'hFF));
        end
        return 8'($urandom_range(8'hF0, 8'hF7));
    endfunction

    initial begin
        exp_t a;
        model_reset();
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        a = dut_out();
        if (a !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h, expected 0", a);
        end
        rst_n = 1'b1;
        @(negedge clk);

        send_seq('{8'h90, 8'h3C, 8'h64}, 0);
        send_seq('{8'h80, 8'h3D, 8'h00}, 1);
        send_seq('{8'h80, 8'h3C, 8'h00}, 0);
        send_seq('{8'h90, 8'h40, 8'h50, 8'h40, 8'h00}, 0);
        send_seq('{8'hB0, 8'd123, 8'h00}, 0);
        send_seq('{8'h90, 8'hF8, 8'h3C, 8'hF8, 8'h64}, 0);
        send_seq('{8'h91, 8'h3C, 8'h64}, 0);
        send_seq('{8'hF0, 8'h3C, 8'h64, 8'hF7, 8'h90, 8'h3C, 8'h64}, 2);
        send_seq('{8'hC0, 8'h05, 8'h90, 8'h3E, 8'h64}, 0);
        send_seq('{8'h90, 8'h3D, 8'h90, 8'h3F, 8'h70}, 0);

        // Reset in the middle of a message drops it.
        send_byte(8'h90, 0);
        send_byte(8'h3C, 1);
        rst_n = 1'b0;
        #1;
        checks++;
        a = dut_out();
        if (a !== '0) begin
            errors++;
            $display("FAIL async_reset: got %h, expected 0", a);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_seq('{8'h64}, 0);

        for (int i = 0; i < 3000; i++) send_byte(rand_byte(), $urandom_range(0, 2));
        repeat (4) @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
